note_scheduler: RTL and testbench

NOTE_SCHEDULER -- requirements
Module: note_scheduler

---
 rtl/audio_pkg.sv | 26 ++
 rtl/note_scheduler_if.sv | 28 ++
 rtl/note_scheduler_step_timer.sv | 45 ++++
 rtl/note_scheduler.sv | 141 ++++++++++++++
 tb/tb_note_scheduler.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding, parameter defaults and note half-period table
package audio_pkg;

  // Parameter defaults shared by the scheduler and anything that drives it
  localparam int HP_W_DEF   = 7;
  localparam int STEP_W_DEF = 7;
  localparam int TICK_W_DEF = 5;

  // Scheduler FSM encoding; IDLE must stay all-zero so busy is a plain OR-reduce
  typedef logic [1:0] sched_state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  // Note half-periods in synthesizer clock units; zero is reserved for a rest
  localparam logic [6:0] NOTE_REST = 7'd0;
  localparam logic [6:0] NOTE_C4   = 7'd95;
  localparam logic [6:0] NOTE_D4   = 7'd85;
  localparam logic [6:0] NOTE_E4   = 7'd75;
  localparam logic [6:0] NOTE_F4   = 7'd71;
  localparam logic [6:0] NOTE_G4   = 7'd63;
  localparam logic [6:0] NOTE_A4   = 7'd56;
  localparam logic [6:0] NOTE_B4   = 7'd50;
  localparam logic [6:0] NOTE_C5   = 7'd47;

endpackage

// File: rtl/note_scheduler_if.sv
// rtl/note_scheduler_if.sv - pattern memory fetch bus between scheduler and pattern store
interface note_scheduler_if #(
  parameter int HP_W   = 7,
  parameter int STEP_W = 7
);

  logic              pat_req;
  logic [STEP_W-1:0] pat_addr;
  logic              pat_ack;
  logic [HP_W-1:0]   pat_note;

  // Scheduler side issues requests and receives notes
  modport master (
    output pat_req,
    output pat_addr,
    input  pat_ack,
    input  pat_note
  );

  // Pattern store side answers requests
  modport slave (
    input  pat_req,
    input  pat_addr,
    output pat_ack,
    output pat_note
  );

endinterface

// File: rtl/note_scheduler_step_timer.sv
// rtl/note_scheduler_step_timer.sv - per-step tick counter with terminal and gate compares
module note_scheduler_step_timer #(
  parameter int TICK_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [TICK_W-1:0] step_len,
  input  logic [TICK_W-1:0] gate_len,
  output logic              terminal,
  output logic              gate
);

  logic [TICK_W-1:0] tick_ctr_q;
  logic [TICK_W-1:0] tick_ctr_d;
  logic [TICK_W-1:0] last_tick;

  // A zero step length behaves like one tick per step
  always_comb begin
    last_tick = (step_len == '0) ? '0 : step_len - TICK_W'(1);
    terminal  = (tick_ctr_q == last_tick);
    gate      = (tick_ctr_q < gate_len);
  end

  // Counter is held at zero while cleared so a new step always starts at tick 0
  always_comb begin
    tick_ctr_d = tick_ctr_q;
    if (clr) begin
      tick_ctr_d = '0;
    end else if (inc) begin
      tick_ctr_d = tick_ctr_q + TICK_W'(1);
    end
  end

  // Tick counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_ctr_q <= '0;
    end else begin
      tick_ctr_q <= tick_ctr_d;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - step sequencer fetching note half-periods and gating the synthesizer
module note_scheduler
  import audio_pkg::*;
#(
  parameter int HP_W   = HP_W_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int TICK_W = TICK_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_en,
  input  logic              start,
  input  logic              stop,
  input  logic [TICK_W-1:0] step_len,
  input  logic [TICK_W-1:0] gate_len,
  input  logic [STEP_W-1:0] loop_end,
  note_scheduler_if.master  pat,
  output logic [HP_W-1:0]   hp,
  output logic              active,
  output logic [STEP_W-1:0] step,
  output logic              step_strobe,
  output logic              busy
);

  sched_state_t      state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              active_q, active_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              strobe_q, strobe_d;
  logic [TICK_W-1:0] step_len_s_q, step_len_s_d;
  logic [TICK_W-1:0] gate_len_s_q, gate_len_s_d;
  logic [STEP_W-1:0] loop_end_s_q, loop_end_s_d;

  logic tmr_clr;
  logic tmr_inc;
  logic tmr_terminal;
  logic tmr_gate;

  // The timer only runs in PLAY; everywhere else it sits at zero
  assign tmr_clr = (state_q != ST_PLAY);

  note_scheduler_step_timer #(
    .TICK_W(TICK_W)
  ) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .inc      (tmr_inc),
    .step_len (step_len_s_q),
    .gate_len (gate_len_s_q),
    .terminal (tmr_terminal),
    .gate     (tmr_gate)
  );

  // Next-state logic: stop overrides everything, ticks outside PLAY are simply not consumed
  always_comb begin
    state_d      = state_q;
    hp_d         = hp_q;
    step_d       = step_q;
    strobe_d     = 1'b0;
    step_len_s_d = step_len_s_q;
    gate_len_s_d = gate_len_s_q;
    loop_end_s_d = loop_end_s_q;
    tmr_inc      = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      hp_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            step_len_s_d = step_len;
            gate_len_s_d = gate_len;
            loop_end_s_d = loop_end;
            step_d       = '0;
            state_d      = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (pat.pat_ack) begin
            hp_d    = pat.pat_note;
            state_d = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick_en) begin
            if (tmr_terminal) begin
              step_d   = (step_q == loop_end_s_q) ? '0 : step_q + STEP_W'(1);
              strobe_d = 1'b1;
              state_d  = ST_FETCH;
            end else begin
              tmr_inc = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Gate follows the tick counter one cycle late and drops together with leaving PLAY
  always_comb begin
    active_d = (state_q == ST_PLAY) && (state_d == ST_PLAY) && tmr_gate && (hp_q != '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hp_q         <= '0;
      active_q     <= 1'b0;
      step_q       <= '0;
      strobe_q     <= 1'b0;
      step_len_s_q <= '0;
      gate_len_s_q <= '0;
      loop_end_s_q <= '0;
    end else begin
      state_q      <= state_d;
      hp_q         <= hp_d;
      active_q     <= active_d;
      step_q       <= step_d;
      strobe_q     <= strobe_d;
      step_len_s_q <= step_len_s_d;
      gate_len_s_q <= gate_len_s_d;
      loop_end_s_q <= loop_end_s_d;
    end
  end

  // The request is decoded straight from state so a reset removes it without waiting for a clock
  assign pat.pat_req  = (state_q == ST_FETCH);
  assign pat.pat_addr = step_q;

  assign hp          = hp_q;
  assign active      = active_q;
  assign step        = step_q;
  assign step_strobe = strobe_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - randomized and directed checks of note_scheduler against a step-level model
module tb_note_scheduler;

  localparam int HP_W   = 7;
  localparam int STEP_W = 7;
  localparam int TICK_W = 5;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              tick_en  = 1'b0;
  logic              start    = 1'b0;
  logic              stop     = 1'b0;
  logic [TICK_W-1:0] step_len = '0;
  logic [TICK_W-1:0] gate_len = '0;
  logic [STEP_W-1:0] loop_end = '0;
  logic [HP_W-1:0]   hp;
  logic              active;
  logic [STEP_W-1:0] step;
  logic              step_strobe;
  logic              busy;

  note_scheduler_if #(.HP_W(HP_W), .STEP_W(STEP_W)) pif ();

  note_scheduler #(
    .HP_W(HP_W), .STEP_W(STEP_W), .TICK_W(TICK_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .start(start), .stop(stop),
    .step_len(step_len), .gate_len(gate_len), .loop_end(loop_end), .pat(pif),
    .hp(hp), .active(active), .step(step), .step_strobe(step_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // stimulus knobs
  bit tick_auto  = 1'b0;
  int tick_pct   = 0;
  int ack_lat    = 1;
  bit ack_rand   = 1'b0;
  bit spurious   = 1'b0;
  bit manual_ack = 1'b0;
  int req_wait   = 0;
  logic [HP_W-1:0] pattern [0:(1<<STEP_W)-1];

  // model: playback described as (playing?, fetching?, note, step, ticks into step)
  int m_busy = 0, m_fetch = 0, m_hp = 0, m_active = 0, m_step = 0, m_strobe = 0, m_ticks = 0;
  int c_len = 0, c_gate = 0, c_end = 0;
  int m_eff, m_act;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_busy = 0; m_fetch = 0; m_hp = 0; m_active = 0; m_step = 0; m_strobe = 0; m_ticks = 0;
    c_len = 0; c_gate = 0; c_end = 0;
  endtask

  task automatic model_step();
    m_strobe = 0;
    if (stop) begin
      m_busy = 0; m_fetch = 0; m_hp = 0; m_active = 0;
    end else if (m_busy == 0) begin
      m_active = 0;
      if (start) begin
        c_len = int'(step_len); c_gate = int'(gate_len); c_end = int'(loop_end);
        m_step = 0; m_busy = 1; m_fetch = 1;
      end
    end else if (m_fetch != 0) begin
      m_active = 0;
      if (pif.pat_ack) begin
        m_hp = int'(pif.pat_note); m_fetch = 0; m_ticks = 0;
      end
    end else begin
      m_eff = (c_len == 0) ? 1 : c_len;
      m_act = (m_ticks < c_gate && m_hp != 0) ? 1 : 0;
      if (tick_en) begin
        if (m_ticks == m_eff - 1) begin
          m_step   = (m_step == c_end) ? 0 : (m_step + 1) % (1 << STEP_W);
          m_strobe = 1; m_fetch = 1; m_act = 0;
        end else begin
          m_ticks++;
        end
      end
      m_active = m_act;
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
  endtask

  // one clock: model consumes the inputs seen at the edge, then new inputs are driven
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    start = 1'b0;
    stop  = 1'b0;
    tick_en = tick_auto && ($urandom_range(0, 99) < tick_pct);
    if (!manual_ack) begin
      if (pif.pat_req) begin
        if (req_wait >= ack_lat) begin
          pif.pat_ack  = 1'b1;
          pif.pat_note = pattern[pif.pat_addr];
          req_wait     = 0;
          if (ack_rand) ack_lat = $urandom_range(0, 4);
        end else begin
          pif.pat_ack = 1'b0;
          req_wait++;
        end
      end else begin
        req_wait     = 0;
        pif.pat_ack  = spurious && ($urandom_range(0, 9) == 0);
        pif.pat_note = HP_W'($urandom);
      end
    end
  endtask

  // cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    chk("busy", int'(busy), m_busy);
    chk("pat_req", int'(pif.pat_req), m_fetch);
    if (m_fetch != 0) chk("pat_addr", int'(pif.pat_addr), m_step);
    chk("hp", int'(hp), m_hp);
    chk("active", int'(active), m_active);
    chk("step", int'(step), m_step);
    chk("step_strobe", int'(step_strobe), m_strobe);
  end

  initial begin
    int hp_seq[$];
    int act_cnt, a0, a1, s_cnt, cnt, bad;
    bit prev_req, done;

    pif.pat_ack  = 1'b0;
    pif.pat_note = '0;
    for (int i = 0; i < (1 << STEP_W); i++) pattern[i] = '0;
    pattern[0] = 7'd47; pattern[1] = 7'd70; pattern[2] = 7'd55;

    #1 assert_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_hp", int'(hp), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_req", int'(pif.pat_req), 0);

    // three-note loop, one tick per cycle, ack one cycle after request
    step_len = 5'd4; gate_len = 5'd2; loop_end = 7'd2;
    tick_auto = 1'b1; tick_pct = 100; ack_lat = 1;
    start = 1'b1;
    prev_req = 1'b0; act_cnt = 0;
    for (int i = 0; i < 200 && hp_seq.size() < 4; i++) begin
      cyc();
      if (prev_req && !pif.pat_req && busy) hp_seq.push_back(int'(hp));
      else if (active && hp_seq.size() >= 1) act_cnt++;
      prev_req = pif.pat_req;
    end
    chk("seq_len", hp_seq.size(), 4);
    while (hp_seq.size() < 4) hp_seq.push_back(-1);
    chk("seq_hp0", hp_seq[0], 47);
    chk("seq_hp1", hp_seq[1], 70);
    chk("seq_hp2", hp_seq[2], 55);
    chk("seq_hp3", hp_seq[3], 47);
    chk("seq_active_cycles", act_cnt, 6);

    // rest at step 1
    stop = 1'b1; cyc();
    pattern[1] = 7'd0;
    start = 1'b1;
    a0 = 0; a1 = 0; s_cnt = 0;
    for (int i = 0; i < 200 && s_cnt < 2; i++) begin
      cyc();
      if (step == 0 && active) a0++;
      if (step == 1 && active) a1++;
      if (step_strobe) s_cnt++;
    end
    chk("rest_step0_active", a0, 2);
    chk("rest_step1_active", a1, 0);
    chk("rest_strobes", s_cnt, 2);
    chk("rest_step_after", int'(step), 2);
    pattern[1] = 7'd70;

    // slow ack with tick pulses during FETCH
    stop = 1'b1; cyc();
    tick_auto = 1'b0; ack_lat = 10;
    start = 1'b1; cyc();
    for (int i = 0; i < 30; i++) begin
      if (i == 1 || i == 3 || i == 5) tick_en = 1'b1;
      cyc();
      if (busy && !pif.pat_req) break;
    end
    chk("slow_ack_play", int'(busy && !pif.pat_req), 1);
    cnt = 0; done = 1'b0;
    for (int k = 1; k <= 10 && !done; k++) begin
      tick_en = 1'b1; cyc();
      cnt = k;
      if (step_strobe) done = 1'b1;
      else cyc();
    end
    chk("slow_ack_ticks_per_step", cnt, 4);

    // stop during PLAY at tick 1, then restart
    ack_lat = 1;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (busy && !pif.pat_req) break;
    end
    chk("stop_reach_play", int'(busy && !pif.pat_req), 1);
    tick_en = 1'b1; cyc();
    stop = 1'b1; cyc();
    chk("stop_busy", int'(busy), 0);
    chk("stop_active", int'(active), 0);
    chk("stop_hp", int'(hp), 0);
    chk("stop_step_kept", int'(step), 1);
    start = 1'b1; cyc();
    chk("restart_req", int'(pif.pat_req), 1);
    chk("restart_addr", int'(pif.pat_addr), 0);

    // start and stop together from IDLE
    stop = 1'b1; cyc();
    start = 1'b1; stop = 1'b1; cyc();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (pif.pat_req || busy) bad++;
      cyc();
    end
    chk("start_stop_idle", bad, 0);

    // reset in the middle of FETCH followed by a stray ack
    ack_lat = 100;
    start = 1'b1; cyc();
    chk("mid_fetch_req", int'(pif.pat_req), 1);
    #2 assert_reset();
    #1;
    chk("reset_drops_req", int'(pif.pat_req), 0);
    cyc();
    rst_n = 1'b1;
    manual_ack = 1'b1; pif.pat_ack = 1'b1; pif.pat_note = 7'd33;
    cyc();
    pif.pat_ack = 1'b0; manual_ack = 1'b0;
    chk("stray_ack_busy", int'(busy), 0);
    chk("stray_ack_hp", int'(hp), 0);
    chk("stray_ack_active", int'(active), 0);
    chk("stray_ack_step", int'(step), 0);
    chk("stray_ack_req", int'(pif.pat_req), 0);
    chk("stray_ack_strobe", int'(step_strobe), 0);

    // randomized playback with live config changes, stops, resets and stray acks
    for (int i = 0; i < (1 << STEP_W); i++)
      pattern[i] = ($urandom_range(0, 3) == 0) ? 7'd0 : HP_W'($urandom_range(1, 127));
    tick_auto = 1'b1; ack_rand = 1'b1; spurious = 1'b1; ack_lat = 2;
    for (int blk = 0; blk < 4; blk++) begin
      tick_pct = (blk == 0) ? 100 : $urandom_range(20, 90);
      for (int i = 0; i < 1000; i++) begin
        cyc();
        if ($urandom_range(0, 99) < 4) start = 1'b1;
        if ($urandom_range(0, 199) < 2) stop = 1'b1;
        if ($urandom_range(0, 99) < 3) begin
          step_len = TICK_W'($urandom_range(0, 6));
          gate_len = TICK_W'($urandom_range(0, 7));
          loop_end = ($urandom_range(0, 9) == 0) ? 7'd127 : STEP_W'($urandom_range(0, 4));
        end
        if ($urandom_range(0, 999) == 0) begin
          #2 assert_reset();
          cyc();
          rst_n = 1'b1;
        end
      end
    end

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
